// File: rtl/tqvp_alonso_rsa_modexp.sv
`default_nettype none
// ============================================================================
//  Module   : tqvp_alonso_rsa_modexp
//  Purpose  : RSA modular exponentiation peripheral for the TinyQV byte bus.
//             Computes P^E mod M on WIDTH-bit operands. The core is a
//             bit-serial Montgomery multiplier driven by a left-to-right
//             square-and-multiply sequencer. Software supplies the modulus M
//             and the Montgomery constant R2 = 2^(2*WIDTH) mod M.
//  Ports    : clk         project clock
//             rst_n       asynchronous active-low reset
//             ui_in       input PMOD (not used)
//             uo_out      mirrors test_reg
//             address     register address
//             data_write  write strobe, data_in valid while high
//             data_in     write data
//             data_out    combinational read data
//  Register map:
//             0x0 test_reg (RW)       0x1 cmd (WO): bit0 start, bit1 abort
//             0x2 byte_sel (RW)       0x3 P, 0x4 E, 0x5 M, 0x6 R2 (RW, wide)
//             0x7 result (RO, wide)   0x8 status: {5'b0, error, busy, done}
//  Revision : 1.0  initial release
// ============================================================================
module tqvp_alonso_rsa_modexp #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int IW     = $clog2(WIDTH);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH);
  localparam logic [IW-1:0] C_IDX_TOP  = IW'(WIDTH - 1);

  localparam logic [3:0] C_ADDR_TEST   = 4'h0;
  localparam logic [3:0] C_ADDR_CMD    = 4'h1;
  localparam logic [3:0] C_ADDR_SEL    = 4'h2;
  localparam logic [3:0] C_ADDR_PLAIN  = 4'h3;
  localparam logic [3:0] C_ADDR_EXP    = 4'h4;
  localparam logic [3:0] C_ADDR_MOD    = 4'h5;
  localparam logic [3:0] C_ADDR_R2     = 4'h6;
  localparam logic [3:0] C_ADDR_RESULT = 4'h7;
  localparam logic [3:0] C_ADDR_STATUS = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MP_X   = 3'd2,
    S_MP_ONE = 3'd3,
    S_SQ     = 3'd4,
    S_MUL    = 3'd5,
    S_MP_OUT = 3'd6
  } state_t;

  state_t r_state;

  // Software-visible registers
  logic [7:0]       r_test_reg;
  logic [7:0]       r_byte_sel;
  logic [WIDTH-1:0] r_plain;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_busy;
  logic             r_error;

  // Working copies latched at start, so software edits cannot disturb a run
  logic [WIDTH-1:0] r_p_w;
  logic [WIDTH-1:0] r_e_w;
  logic [WIDTH-1:0] r_m_w;
  logic [WIDTH-1:0] r_r2_w;

  // Montgomery-domain values: x = P*R mod M, accumulator A
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_a;

  // MonPro engine: partial sum, cycle counter, exponent bit index
  logic [WIDTH+1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_wr_test, w_wr_sel, w_wr_plain, w_wr_exp, w_wr_mod, w_wr_r2;
  logic w_start, w_abort;

  assign w_wr_test  = data_write && (address == C_ADDR_TEST);
  assign w_wr_sel   = data_write && (address == C_ADDR_SEL);
  assign w_wr_plain = data_write && (address == C_ADDR_PLAIN);
  assign w_wr_exp   = data_write && (address == C_ADDR_EXP);
  assign w_wr_mod   = data_write && (address == C_ADDR_MOD);
  assign w_wr_r2    = data_write && (address == C_ADDR_R2);
  assign w_start    = data_write && (address == C_ADDR_CMD) && data_in[0];
  assign w_abort    = data_write && (address == C_ADDR_CMD) && data_in[1];

  // Per-lane write mask; an out-of-range byte_sel yields an all-zero mask,
  // which turns the wide write into a no-op.
  logic [WIDTH-1:0] w_lane_mask;
  logic [WIDTH-1:0] w_wdata_rep;

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    assign w_lane_mask[8*k +: 8] = {8{r_byte_sel == 8'(k)}};
  end

  assign w_wdata_rep = {NBYTES{data_in}};

  logic [WIDTH-1:0] w_plain_nxt, w_exp_nxt, w_mod_nxt, w_r2_nxt;

  assign w_plain_nxt = (r_plain & ~w_lane_mask) | (w_wdata_rep & w_lane_mask);
  assign w_exp_nxt   = (r_exp   & ~w_lane_mask) | (w_wdata_rep & w_lane_mask);
  assign w_mod_nxt   = (r_mod   & ~w_lane_mask) | (w_wdata_rep & w_lane_mask);
  assign w_r2_nxt    = (r_r2    & ~w_lane_mask) | (w_wdata_rep & w_lane_mask);

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_wide_rd;
  logic             w_is_wide;
  logic [7:0]       w_lane_rd;

  always_comb begin
    w_wide_rd = '0;
    w_is_wide = 1'b0;
    case (address)
      C_ADDR_PLAIN:  begin w_is_wide = 1'b1; w_wide_rd = r_plain;  end
      C_ADDR_EXP:    begin w_is_wide = 1'b1; w_wide_rd = r_exp;    end
      C_ADDR_MOD:    begin w_is_wide = 1'b1; w_wide_rd = r_mod;    end
      C_ADDR_R2:     begin w_is_wide = 1'b1; w_wide_rd = r_r2;     end
      C_ADDR_RESULT: begin w_is_wide = 1'b1; w_wide_rd = r_result; end
      default:       ;
    endcase
  end

  assign w_lane_rd = (r_byte_sel < 8'(NBYTES))
                   ? 8'(w_wide_rd >> {r_byte_sel, 3'b000})
                   : 8'h00;

  always_comb begin
    data_out = 8'h00;
    if (w_is_wide) begin
      data_out = w_lane_rd;
    end else begin
      case (address)
        C_ADDR_TEST:   data_out = r_test_reg;
        C_ADDR_SEL:    data_out = r_byte_sel;
        C_ADDR_STATUS: data_out = {5'b00000, r_error, r_busy, r_done};
        default:       data_out = 8'h00;
      endcase
    end
  end

  assign uo_out = r_test_reg;

  logic w_unused;
  assign w_unused = &{1'b0, ui_in};

  // --------------------------------------------------------------------------
  // Montgomery product datapath. Operands are chosen by state, so the
  // sources (A, x, working copies) must stay stable for a whole MonPro.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_MP_X:   begin w_op_a = r_p_w;        w_op_b = r_r2_w;       end
      S_MP_ONE: begin w_op_a = WIDTH'(1);    w_op_b = r_r2_w;       end
      S_SQ:     begin w_op_a = r_a;          w_op_b = r_a;          end
      S_MUL:    begin w_op_a = r_a;          w_op_b = r_x;          end
      S_MP_OUT: begin w_op_a = r_a;          w_op_b = WIDTH'(1);    end
      default:  ;
    endcase
  end

  logic             w_a_bit;
  logic             w_e_bit;
  logic [WIDTH+1:0] w_sum1;
  logic [WIDTH+1:0] w_s_step;
  logic [WIDTH-1:0] w_mp_res;

  assign w_a_bit = |((w_op_a >> r_cnt) & WIDTH'(1));
  assign w_e_bit = |((r_e_w  >> r_idx) & WIDTH'(1));

  // S stays below 2M, so S + b + M < 4M fits in WIDTH+2 bits.
  assign w_sum1   = r_s + (w_a_bit ? {2'b00, w_op_b} : '0);
  assign w_s_step = (w_sum1 + (w_sum1[0] ? {2'b00, r_m_w} : '0)) >> 1;

  // Final conditional subtraction brings the product into [0, M).
  assign w_mp_res = (r_s >= {2'b00, r_m_w}) ? WIDTH'(r_s - {2'b00, r_m_w})
                                            : WIDTH'(r_s);

  // --------------------------------------------------------------------------
  // Registers and sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_test_reg <= '0;
      r_byte_sel <= '0;
      r_plain    <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_r2       <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_p_w      <= '0;
      r_e_w      <= '0;
      r_m_w      <= '0;
      r_r2_w     <= '0;
      r_x        <= '0;
      r_a        <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      if (w_wr_test) r_test_reg <= data_in;
      if (w_wr_sel)  r_byte_sel <= data_in;

      // Operand registers are frozen while a run is in progress.
      if (!r_busy) begin
        if (w_wr_plain) r_plain <= w_plain_nxt;
        if (w_wr_exp)   r_exp   <= w_exp_nxt;
        if (w_wr_mod)   r_mod   <= w_mod_nxt;
        if (w_wr_r2)    r_r2    <= w_r2_nxt;
      end

      if (w_abort) begin
        // Abort has priority over a start in the same write.
        if (r_busy) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end else if (w_start && !r_busy) begin
        r_done <= 1'b0;
        if (!r_mod[0]) begin
          // Montgomery reduction needs an odd modulus.
          r_error <= 1'b1;
        end else begin
          r_error <= 1'b0;
          r_busy  <= 1'b1;
          r_p_w   <= r_plain;
          r_e_w   <= r_exp;
          r_m_w   <= r_mod;
          r_r2_w  <= r_r2;
          r_state <= S_LOAD;
        end
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD: begin
            r_s     <= '0;
            r_cnt   <= '0;
            r_state <= S_MP_X;
          end
          default: begin
            if (r_cnt != C_CNT_LAST) begin
              r_s   <= w_s_step;
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_s   <= '0;
              r_cnt <= '0;
              case (r_state)
                S_MP_X: begin
                  r_x     <= w_mp_res;
                  r_state <= S_MP_ONE;
                end
                S_MP_ONE: begin
                  r_a     <= w_mp_res;
                  r_idx   <= C_IDX_TOP;
                  r_state <= S_SQ;
                end
                S_SQ: begin
                  r_a <= w_mp_res;
                  if (w_e_bit) begin
                    r_state <= S_MUL;
                  end else if (r_idx == '0) begin
                    r_state <= S_MP_OUT;
                  end else begin
                    r_idx   <= r_idx - IW'(1);
                    r_state <= S_SQ;
                  end
                end
                S_MUL: begin
                  r_a <= w_mp_res;
                  if (r_idx == '0) begin
                    r_state <= S_MP_OUT;
                  end else begin
                    r_idx   <= r_idx - IW'(1);
                    r_state <= S_SQ;
                  end
                end
                S_MP_OUT: begin
                  r_result <= w_mp_res;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_alonso_rsa_modexp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tqvp_alonso_rsa_modexp
//  Purpose  : Self-checking bench for the RSA modexp peripheral. One 8-bit
//             and one 16-bit instance share clock and reset; each has its
//             own bus. Table of directed 8-bit vectors plus hand sequences
//             for error, byte lanes, abort, test_reg and async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tqvp_alonso_rsa_modexp;

  localparam logic [3:0] A_TEST = 4'h0, A_CMD = 4'h1, A_SEL = 4'h2,
                         A_P = 4'h3, A_E = 4'h4, A_M = 4'h5, A_R2 = 4'h6,
                         A_RES = 4'h7, A_ST = 4'h8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui = 8'h00;

  logic [3:0] a8 = '0, a16 = '0;
  logic       dw8 = 1'b0, dw16 = 1'b0;
  logic [7:0] di8 = '0, di16 = '0;
  logic [7:0] do8, do16, uo8, uo16;

  tqvp_alonso_rsa_modexp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui), .uo_out(uo8),
    .address(a8), .data_write(dw8), .data_in(di8), .data_out(do8)
  );

  tqvp_alonso_rsa_modexp #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui), .uo_out(uo16),
    .address(a16), .data_write(dw16), .data_in(di16), .data_out(do16)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string      name;
    logic [7:0] p, e, m, r2, res;
    int         cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Write lands on the posedge between the two negedges.
  task automatic wr(input bit w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    if (w) begin a16 = a; di16 = d; dw16 = 1'b1; end
    else   begin a8  = a; di8  = d; dw8  = 1'b1; end
    @(negedge clk);
    dw8 = 1'b0; dw16 = 1'b0;
  endtask

  task automatic rd(input bit w, input logic [3:0] a, output logic [7:0] d);
    if (w) a16 = a; else a8 = a;
    #1;
    d = w ? do16 : do8;
  endtask

  // Called at the negedge following the start edge; counts edges until done.
  task automatic wait_done(input bit w, output int cyc, output bit both);
    logic [7:0] st;
    cyc  = 0;
    both = 1'b0;
    forever begin
      rd(w, A_ST, st);
      if (st[1:0] == 2'b11) both = 1'b1;
      if (st[0] || cyc >= 1000) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load8(input vec_t v);
    wr(0, A_SEL, 8'h00);
    wr(0, A_P, v.p);
    wr(0, A_E, v.e);
    wr(0, A_M, v.m);
    wr(0, A_R2, v.r2);
  endtask

  task automatic run8(input vec_t v);
    logic [7:0] d;
    int         cyc;
    bit         both;
    load8(v);
    wr(0, A_CMD, 8'h01);
    rd(0, A_ST, d);
    chk({v.name, " busy after start"}, d, 8'h02);
    wait_done(0, cyc, both);
    chk({v.name, " latency"}, cyc, v.cyc);
    chk({v.name, " busy&done overlap"}, both, 1'b0);
    rd(0, A_ST, d);
    chk({v.name, " status done"}, d, 8'h01);
    rd(0, A_RES, d);
    chk({v.name, " result"}, d, v.res);
  endtask

  initial begin
    logic [7:0] d;
    int         cyc;
    bit         both;
    bit         saw_busy;
    logic [7:0] last_res8;

    // Latency = 1 + 9*(11 + popcount(E)) for WIDTH=8.
    vecs[0] = '{"enc",   8'h58, 8'h07, 8'hBB, 8'h56, 8'h0B, 127};
    vecs[1] = '{"dec",   8'h0B, 8'h17, 8'hBB, 8'h56, 8'h58, 136};
    vecs[2] = '{"e0",    8'h05, 8'h00, 8'hBB, 8'h56, 8'h01, 100};
    vecs[3] = '{"e1",    8'h58, 8'h01, 8'hBB, 8'h56, 8'h58, 109};
    vecs[4] = '{"p>m",   8'hFF, 8'h01, 8'hBB, 8'h56, 8'h44, 109};
    vecs[5] = '{"eFF",   8'h02, 8'hFF, 8'hBB, 8'h56, 8'h2B, 172};
    vecs[6] = '{"m1",    8'h05, 8'h03, 8'h01, 8'h00, 8'h00, 118};

    // Reset state
    repeat (3) @(negedge clk);
    rd(0, A_ST, d);   chk("rst status8", d, 8'h00);
    rd(0, A_RES, d);  chk("rst result8", d, 8'h00);
    rd(0, A_TEST, d); chk("rst test_reg8", d, 8'h00);
    chk("rst uo_out8", uo8, 8'h00);
    rd(1, A_ST, d);   chk("rst status16", d, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 7; i++) run8(vecs[i]);

    // E=0 then even modulus -> error, busy never set, result preserved
    run8(vecs[2]);
    wr(0, A_M, 8'hBA);
    wr(0, A_CMD, 8'h01);
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd(0, A_ST, d);
      if (d[1]) saw_busy = 1'b1;
      @(negedge clk);
    end
    rd(0, A_ST, d);  chk("err status", d, 8'h04);
    chk("err busy seen", saw_busy, 1'b0);
    rd(0, A_RES, d); chk("err result kept", d, 8'h01);
    last_res8 = 8'h01;

    // Out-of-range lane on 8-bit instance
    wr(0, A_SEL, 8'h01);
    rd(0, A_RES, d); chk("w8 lane1 result", d, 8'h00);
    wr(0, A_M, 8'h77);
    wr(0, A_SEL, 8'h00);
    rd(0, A_M, d);   chk("w8 lane1 write ignored", d, 8'hBA);

    // 16-bit instance, two lanes
    wr(1, A_SEL, 8'h00);
    wr(1, A_M, 8'hA1); wr(1, A_R2, 8'h83); wr(1, A_P, 8'h41); wr(1, A_E, 8'h11);
    wr(1, A_SEL, 8'h01);
    wr(1, A_M, 8'h0C); wr(1, A_R2, 8'h04); wr(1, A_P, 8'h00); wr(1, A_E, 8'h00);
    wr(1, A_CMD, 8'h01);
    wait_done(1, cyc, both);
    chk("w16 latency", cyc, 358);
    chk("w16 busy&done overlap", both, 1'b0);
    wr(1, A_SEL, 8'h00); rd(1, A_RES, d); chk("w16 result lane0", d, 8'hE6);
    wr(1, A_SEL, 8'h01); rd(1, A_RES, d); chk("w16 result lane1", d, 8'h0A);
    wr(1, A_SEL, 8'h02); rd(1, A_RES, d); chk("w16 result lane2", d, 8'h00);

    // Abort sequence
    load8(vecs[0]);
    wr(0, A_CMD, 8'h01);
    repeat (48) @(negedge clk);
    wr(0, A_P, 8'hFF);
    wr(0, A_CMD, 8'h01);
    rd(0, A_ST, d);  chk("mid-run status busy", d, 8'h02);
    wr(0, A_CMD, 8'h02);
    rd(0, A_ST, d);  chk("abort status", d, 8'h00);
    rd(0, A_RES, d); chk("abort result kept", d, last_res8);
    rd(0, A_P, d);   chk("busy P write ignored", d, 8'h58);
    wr(0, A_CMD, 8'h02);
    rd(0, A_ST, d);  chk("idle abort no effect", d, 8'h00);

    // Start+abort in one write while idle: abort wins, nothing starts
    wr(0, A_CMD, 8'h03);
    rd(0, A_ST, d);  chk("start+abort", d, 8'h00);

    // test_reg while busy
    wr(0, A_CMD, 8'h01);
    repeat (10) @(negedge clk);
    wr(0, A_TEST, 8'hA5);
    #1;
    chk("uo_out busy write", uo8, 8'hA5);
    rd(0, A_TEST, d); chk("test_reg read", d, 8'hA5);
    rd(0, 4'hF, d);   chk("unmapped read", d, 8'h00);
    rd(0, A_CMD, d);  chk("cmd read", d, 8'h00);
    @(negedge clk);
    rd(0, A_ST, d);   chk("still busy", d, 8'h02);

    // Asynchronous reset mid-run, no clock edge in between
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst uo_out", uo8, 8'h00);
    rd(0, A_ST, d);   chk("async rst status", d, 8'h00);
    rd(0, A_RES, d);  chk("async rst result", d, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tqvp_alonso_rsa_modexp.md
# tqvp_alonso_rsa_modexp

Parametrised RSA modular-exponentiation peripheral for the TinyQV byte-peripheral bus: computes P^E mod M on WIDTH-bit operands with a bit-serial Montgomery multiplier. It is the next generation of the team's register-only RSA peripheral. It adds a working exponentiation engine, start/abort/busy/done/error handshaking, and operands wider than one byte accessed through a byte-lane select. Software supplies the modulus M and the Montgomery constant R2 = 2^(2·WIDTH) mod M.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of 8 in the range 8..32; R = 2^WIDTH
- clk  in  1  project clock, nominally 64 MHz
- rst_n  in  1  reset; one clock, asynchronous, active-low
- ui_in  in  8  input PMOD; unused
- uo_out  out  8  mirrors test_reg
- address  in  4  register address
- data_write  in  1  write strobe; data_in is valid while this is high
- data_in  in  8  write data
- data_out  out  8  combinational read mux; unmapped addresses read 0x00

## Operation
- Address map:
  - 0x0 test_reg (RW)
  - 0x1 cmd (WO, reads 0): bit0 start, bit1 abort; both are pulses and are not stored
  - 0x2 byte_sel (RW, 8 bits)
  - 0x3 plain P, 0x4 exp E, 0x5 mod M, 0x6 r2 (RW, WIDTH bits each)
  - 0x7 result (RO)
  - 0x8 status (RO): bit0 done, bit1 busy, bit2 error, bits[7:3] = 0
- Wide registers (0x3–0x7) are accessed one byte at a time: lane byte_sel, bits [8·byte_sel+7 : 8·byte_sel].
  - byte_sel ≥ WIDTH/8: writes are ignored and reads return 0.
- While busy, writes to 0x3–0x6 are ignored. test_reg and byte_sel stay writable at all times.
- Start while busy is ignored. Start with M[0]=0 sets error, clears done, and leaves busy low.
- Start with M odd: clears done and error, sets busy, and latches P/E/M/R2 into working copies.
- FSM: IDLE → LOAD → MP_X → MP_ONE → loop → MP_OUT → IDLE.
  - LOAD: 1 cycle.
  - MP_X: x = MonPro(P, R2).
  - MP_ONE: A = MonPro(1, R2).
  - Loop for i = WIDTH-1 down to 0: SQ computes A = MonPro(A, A); if E[i] = 1, MUL computes A = MonPro(A, x). When E[i] = 0, MUL is skipped and costs no cycles.
  - MP_OUT: result = MonPro(A, 1).
  - At MP_OUT completion: result register updates, done = 1, busy = 0.
- MonPro(a, b) is bit-serial, WIDTH+1 cycles:
  - Cycles 0..WIDTH-1: S = S + a[j]·b; if S is odd, S = S + M; then S = S >> 1.
  - Cycle WIDTH: if S ≥ M, S = S − M.
  - S starts at 0 and is WIDTH+2 bits wide; no overflow is permitted.
- Any P < R is accepted; the result is P^E mod M, always < M.
- E = 0 gives 1 mod M. M = 1 gives 0.
- Abort while busy: FSM goes to IDLE on the next edge, busy = 0, done stays 0, result keeps its previous value. Abort while idle has no effect.
- Start and abort in the same write: abort wins.
- Reset (asynchronous, including mid-run): every register goes to 0, FSM to IDLE, data_out reflects zeros.

## Timing
- Reset values: uo_out = 0x00, status = 0x00, result = 0, all RW registers = 0.
- A write takes effect at the clock edge where data_write is high. Reads are combinational in the same cycle.
- busy is high from the edge after the start write through the final cycle of MP_OUT.
- Latency, counted from the start-write edge to the edge where done rises: 1 + (WIDTH+1)·(3 + WIDTH + popcount(E)) cycles.
- done and error are sticky until the next accepted start.
- busy and done are never high at the same time.

## Test plan
- WIDTH=8; M=0xBB, R2=0x56, P=0x58, E=0x07; start. Required: busy goes high, done rises after exactly 127 cycles, result reads 0x0B.
- WIDTH=8; decrypt with M=0xBB, R2=0x56, P=0x0B, E=0x17. Required: result 0x58 after 136 cycles.
- WIDTH=8; E=0x00, P=0x05, M=0xBB. Required: result 0x01 after 100 cycles. Then M=0xBA with start. Required: status 0x04, busy never high, result still 0x01.
- WIDTH=16:
  - Set byte_sel and write M=0x0CA1, R2=0x0483, P=0x0041, E=0x0011; start.
  - Required: done after 358 cycles. Reading result with byte_sel=0 gives 0xE6; with byte_sel=1 gives 0x0A; with byte_sel=2 gives 0x00.
- WIDTH=8; start the first vector, then at cycle 50:
  - Write P=0xFF. Required: ignored.
  - Issue a second start. Required: ignored.
  - Issue abort. Required: status becomes 0x00 on the next cycle and result is unchanged.
  - Then assert rst_n low asynchronously mid-run with no clock edge. Required: status, result, and uo_out read 0 immediately.
- test_reg: write 0xA5 while busy. Required: uo_out = 0xA5 and address 0x0 reads 0xA5. Address 0xF reads 0x00; cmd reads 0x00.
